// File: rtl/cache_nway.sv
// cache_nway: N-way set-associative, write-back, write-allocate data cache.
// A single-word CPU port stalls through `miss`. A line-wide memory port handles
// writeback and fill using a req/gnt handshake.
// Build macro LRU_EN: when defined, each set uses age-based LRU replacement.
// When it is undefined (the default), each set uses a round-robin FIFO pointer.
module cache_nway #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 7,
  parameter int WAY_CNT       = 4,
  localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN,
  localparam int LINE_SIZE    = 2 ** LINE_ADDR_LEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic                      rd_req,
  input  logic                      wr_req,
  input  logic [31:0]               wr_data,
  output logic [31:0]               rd_data,
  output logic                      miss,
  output logic [MEM_ADDR_LEN-1:0]   mem_addr,
  output logic                      mem_rd_req,
  output logic                      mem_wr_req,
  output logic [32*LINE_SIZE-1:0]   mem_wr_line,
  input  logic [32*LINE_SIZE-1:0]   mem_rd_line,
  input  logic                      mem_gnt,
  output logic [31:0]               hit_cnt,
  output logic [31:0]               miss_cnt
);
  localparam int SET_SIZE = 2 ** SET_ADDR_LEN;
  localparam int WAY_W    = $clog2(WAY_CNT);
  localparam int LINE_W   = 32 * LINE_SIZE;
  localparam int ADDR_TOP = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;

  // Address decomposition: {unused, tag, set, word-in-line, byte}
  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  tag_in;
  logic                     unused_addr_bits;
  assign word_idx = addr[2 +: LINE_ADDR_LEN];
  assign set_idx  = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign tag_in   = addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
  assign unused_addr_bits = ^{addr[31:ADDR_TOP], addr[1:0]};

  // Line storage (tags and data carry no reset; validity is tracked separately)
  logic [31:0]             data_mem [SET_SIZE][WAY_CNT][LINE_SIZE];
  logic [TAG_ADDR_LEN-1:0] tag_mem  [SET_SIZE][WAY_CNT];
  logic [WAY_CNT-1:0]      valid_q  [SET_SIZE];
  logic [WAY_CNT-1:0]      dirty_q  [SET_SIZE];

  // FSM and output registers
  state_t                  state_q, state_d;
  logic [WAY_W-1:0]        victim_q, victim_d;
  logic [TAG_ADDR_LEN-1:0] tag_lat_q, tag_lat_d;
  logic [SET_ADDR_LEN-1:0] set_lat_q, set_lat_d;
  logic [LINE_W-1:0]       fill_line_q, fill_line_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;
  logic [MEM_ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic                    mem_rd_req_q, mem_rd_req_d;
  logic                    mem_wr_req_q, mem_wr_req_d;
  logic [LINE_W-1:0]       mem_wr_line_q, mem_wr_line_d;

  logic [WAY_CNT-1:0] hit_vec;
  logic               hit;
  logic               req_any;
  logic               served;
  logic               serve_wr;
  logic               fill_en;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   policy_way;
  logic [WAY_W-1:0]   victim_way;
  logic [LINE_W-1:0]  victim_line;

  // Per-way tag compare and victim line readout
  genvar gi;
  generate
    for (gi = 0; gi < WAY_CNT; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_q[set_idx][gi] && (tag_mem[set_idx][gi] == tag_in);
    end
    for (gi = 0; gi < LINE_SIZE; gi++) begin : g_vline
      assign victim_line[32*gi +: 32] = data_mem[set_idx][victim_way][gi];
    end
  endgenerate

  assign hit      = |hit_vec;
  assign req_any  = rd_req | wr_req;
  assign served   = req_any & hit & (state_q == IDLE);
  assign serve_wr = served & wr_req & ~rd_req;
  assign fill_en  = (state_q == SWAP_IN_OK);
  assign miss     = req_any & ~(hit & (state_q == IDLE));

  // Encode the matching way (at most one way matches)
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // Victim is the lowest invalid way; if every way is valid, use the policy way
  always_comb begin
    victim_way = policy_way;
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) victim_way = WAY_W'(w);
    end
  end

`ifdef LRU_EN
  logic [WAY_W-1:0]        age_q [SET_SIZE][WAY_CNT];
  logic                    touch_en;
  logic [WAY_W-1:0]        touch_way;
  logic [SET_ADDR_LEN-1:0] touch_set;

  assign touch_en  = served | fill_en;
  assign touch_way = fill_en ? victim_q : hit_way;
  assign touch_set = fill_en ? set_lat_q : set_idx;

  // The oldest way (age WAY_CNT-1) is the replacement candidate
  always_comb begin
    policy_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (age_q[set_idx][w] == WAY_W'(WAY_CNT - 1)) policy_way = WAY_W'(w);
    end
  end

  // Age update: ways younger than the touched way get one step older; the touched way becomes youngest
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SET_SIZE; s++)
        for (int w = 0; w < WAY_CNT; w++)
          age_q[s][w] <= WAY_W'(w);
    end else if (touch_en) begin
      for (int w = 0; w < WAY_CNT; w++) begin
        if (age_q[touch_set][w] < age_q[touch_set][touch_way])
          age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
      end
      age_q[touch_set][touch_way] <= '0;
    end
  end
`else
  logic [WAY_W-1:0] fifo_q [SET_SIZE];

  assign policy_way = fifo_q[set_idx];

  // The pointer advances only when a fill lands in the way it points at
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SET_SIZE; s++) fifo_q[s] <= '0;
    end else if (fill_en && (victim_q == fifo_q[set_lat_q])) begin
      fifo_q[set_lat_q] <= fifo_q[set_lat_q] + 1'b1;
    end
  end
`endif

  // Next-state and registered-output logic for the miss-handling FSM
  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    tag_lat_d     = tag_lat_q;
    set_lat_d     = set_lat_q;
    fill_line_d   = fill_line_q;
    rd_data_d     = rd_data_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_req_d  = mem_rd_req_q;
    mem_wr_req_d  = mem_wr_req_q;
    mem_wr_line_d = mem_wr_line_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (hit) begin
            if (rd_req) rd_data_d = data_mem[set_idx][hit_way][word_idx];
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            victim_d  = victim_way;
            tag_lat_d = tag_in;
            set_lat_d = set_idx;
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
              state_d       = SWAP_OUT;
              mem_wr_req_d  = 1'b1;
              mem_addr_d    = {tag_mem[set_idx][victim_way], set_idx};
              mem_wr_line_d = victim_line;
            end else begin
              state_d      = SWAP_IN;
              mem_rd_req_d = 1'b1;
              mem_addr_d   = {tag_in, set_idx};
            end
          end
        end
      end
      SWAP_OUT: begin
        if (mem_gnt) begin
          state_d      = SWAP_IN;
          mem_wr_req_d = 1'b0;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = {tag_lat_q, set_lat_q};
        end
      end
      SWAP_IN: begin
        if (mem_gnt) begin
          state_d      = SWAP_IN_OK;
          fill_line_d  = mem_rd_line;
          mem_rd_req_d = 1'b0;
          mem_addr_d   = '0;
        end
      end
      SWAP_IN_OK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      victim_q      <= '0;
      tag_lat_q     <= '0;
      set_lat_q     <= '0;
      fill_line_q   <= '0;
      rd_data_q     <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      mem_addr_q    <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
      mem_wr_line_q <= '0;
    end else begin
      state_q       <= state_d;
      victim_q      <= victim_d;
      tag_lat_q     <= tag_lat_d;
      set_lat_q     <= set_lat_d;
      fill_line_q   <= fill_line_d;
      rd_data_q     <= rd_data_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_req_q  <= mem_wr_req_d;
      mem_wr_line_q <= mem_wr_line_d;
    end
  end

  // Data/tag storage writes: word writes on write hits, whole lines on fills
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (serve_wr) data_mem[set_idx][hit_way][word_idx] <= wr_data;
      if (fill_en) begin
        for (int i = 0; i < LINE_SIZE; i++)
          data_mem[set_lat_q][victim_q][i] <= fill_line_q[32*i +: 32];
        tag_mem[set_lat_q][victim_q] <= tag_lat_q;
      end
    end
  end

  // Valid/dirty bits; reset discards every line, including dirty ones
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SET_SIZE; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (serve_wr) dirty_q[set_idx][hit_way] <= 1'b1;
      if (fill_en) begin
        valid_q[set_lat_q][victim_q] <= 1'b1;
        dirty_q[set_lat_q][victim_q] <= 1'b0;
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign hit_cnt     = hit_cnt_q;
  assign miss_cnt    = miss_cnt_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_wr_line = mem_wr_line_q;
endmodule
